core_data_arbiter: RTL and testbench

//  Shares the single core-side data port of the AXI bridge between two requesters:

---
 rtl/core_arb_pkg.sv | 16 +
 rtl/core_arb_id_fifo.sv | 62 ++++++
 rtl/core_data_arbiter.sv | 134 +++++++++++++
 tb/tb_core_data_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// Shared types for the core data-port arbiter.
// owner_e tags which requester issued a transaction; arb_state_e is the
// arbitration FSM state (free arbitration vs. selection frozen until granted).
package core_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_AUX  = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/core_arb_id_fifo.sv
// Owner FIFO: remembers, in issue order, which requester owns each in-flight transaction.
// Latency: head is combinational from storage; push/pop take effect at the next edge.
// Backpressure: push ignored when full, pop ignored when empty; same-cycle push+pop safe.
// Ports: clk/rst, push+din, pop, dout (head entry), count, full, empty.
module core_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Explicit wrap keeps DEPTH=1 correct, where the pointer bit would otherwise toggle.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_data_arbiter.sv
// Round-robin arbiter sharing the bridge data port between core LSU (port 0) and aux (port 1).
// Latency: zero-cycle request/grant and rvalid/rdata paths; owner FIFO updates at the edge.
// Backpressure: a stalled request freezes selection until granted; no requests while MAX_OUTSTANDING are in flight.
// Ports: m0_*/m1_* requester side, s_* bridge side, err_o flags a response with nothing outstanding.
module core_data_arbiter
  import core_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic [31:0]           m1_rdata_o,
  output logic                  s_req_o,
  input  logic                  s_gnt_i,
  input  logic                  s_rvalid_i,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic                  s_we_o,
  output logic [3:0]            s_be_o,
  output logic [31:0]           s_wdata_o,
  input  logic [31:0]           s_rdata_i,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e        state_q, state_d;
  owner_e            lock_owner_q, lock_owner_d;
  owner_e            rr_ptr_q;
  owner_e            sel;
  logic              sel_req;
  logic              req_int;
  logic              grant;
  logic              pop;
  logic              full;
  logic              empty;
  logic [0:0]        head;
  logic [CNT_W-1:0]  count;
  logic              count_unused;

  // Selection: frozen while locked, otherwise lone requester or round-robin tie-break.
  always_comb begin
    sel = OWNER_CORE;
    if (state_q == ARB_LOCKED)       sel = lock_owner_q;
    else if (m0_req_i && m1_req_i)   sel = rr_ptr_q;
    else if (m1_req_i)               sel = OWNER_AUX;
  end

  assign sel_req = (sel == OWNER_AUX) ? m1_req_i : m0_req_i;
  assign req_int = sel_req & ~full;
  assign grant   = req_int & s_gnt_i & ~rst_i;
  assign pop     = s_rvalid_i & ~empty;

  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_int && !s_gnt_i) begin
          state_d      = ARB_LOCKED;
          lock_owner_d = sel;
        end
      end
      ARB_LOCKED: begin
        if (grant) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      lock_owner_q <= OWNER_CORE;
      rr_ptr_q     <= OWNER_CORE;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      if (grant) rr_ptr_q <= owner_e'(~sel);
    end
  end

  core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .din   (sel),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Occupancy is tracked through full/empty; the raw count is not needed here.
  assign count_unused = ^count;

  // Every output is forced low while reset is held, including the pass-through paths.
  assign s_req_o     = req_int & ~rst_i;
  assign s_addr_o    = rst_i ? '0 : ((sel == OWNER_AUX) ? m1_addr_i  : m0_addr_i);
  assign s_we_o      = rst_i ? '0 : ((sel == OWNER_AUX) ? m1_we_i    : m0_we_i);
  assign s_be_o      = rst_i ? '0 : ((sel == OWNER_AUX) ? m1_be_i    : m0_be_i);
  assign s_wdata_o   = rst_i ? '0 : ((sel == OWNER_AUX) ? m1_wdata_i : m0_wdata_i);

  assign m0_gnt_o    = grant & (sel == OWNER_CORE);
  assign m1_gnt_o    = grant & (sel == OWNER_AUX);

  assign m0_rvalid_o = pop & ~rst_i & (head == 1'b0);
  assign m1_rvalid_o = pop & ~rst_i & (head == 1'b1);
  assign m0_rdata_o  = rst_i ? '0 : s_rdata_i;
  assign m1_rdata_o  = rst_i ? '0 : s_rdata_i;

  // A response with nothing outstanding is dropped and flagged.
  assign err_o       = s_rvalid_i & empty & ~rst_i;

endmodule

// File: tb/tb_core_data_arbiter.sv
module tb_core_data_arbiter;

  localparam int AW = 32;
  localparam int MO = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [3:0]    m0_be_i;
  logic [31:0]   m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [3:0]    m1_be_i;
  logic [31:0]   m1_wdata_i, m1_rdata_o;
  logic          s_req_o, s_gnt_i, s_rvalid_i, s_we_o, err_o;
  logic [AW-1:0] s_addr_o;
  logic [3:0]    s_be_o;
  logic [31:0]   s_wdata_o, s_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  core_data_arbiter #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return mid-cycle for checking.
  task automatic step(input logic r0, input logic r1, input logic g, input logic rv,
                      input logic [31:0] rd);
    @(posedge clk_i); #1;
    m0_req_i = r0; m1_req_i = r1; s_gnt_i = g; s_rvalid_i = rv; s_rdata_i = rd;
    #3;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Reference model state: request-level view of the shared port.
  int          q[$];
  int          rr, lk_own, e_sel;
  bit          lk;
  bit          hold[2];
  logic [31:0] ra[2], rw[2];
  logic        rwe[2];
  logic [3:0]  rbe[2];
  logic        gnt, rv, e_req, e_g0, e_g1, e_rv0, e_rv1, e_err;
  logic [31:0] rd;

  initial begin
    // Reset asserted with busy inputs: every output must read 0.
    rst_i = 1'b1;
    m0_addr_i = 32'h1000; m0_we_i = 0; m0_be_i = 4'hF; m0_wdata_i = 32'h0A0A0A0A;
    m1_addr_i = 32'h2000; m1_we_i = 1; m1_be_i = 4'h3; m1_wdata_i = 32'h1B1B1B1B;
    m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hFFFF_FFFF;
    #2;
    chk1("rst_s_req", s_req_o, 0);
    chk1("rst_m0_gnt", m0_gnt_o, 0);
    chk1("rst_m0_rvalid", m0_rvalid_o, 0);
    chk1("rst_err", err_o, 0);
    chk32("rst_s_addr", s_addr_o, 0);
    chk32("rst_m0_rdata", m0_rdata_o, 0);
    do_reset();

    // 1: single read from m0, response two cycles later.
    step(1, 0, 1, 0, 0);
    chk1("t1_m0_gnt", m0_gnt_o, 1);   chk1("t1_m1_gnt", m1_gnt_o, 0);
    chk32("t1_addr", s_addr_o, 32'h1000); chk1("t1_we", s_we_o, 0);
    step(0, 0, 0, 0, 0);
    chk1("t1_rv_early", m0_rvalid_o, 0);
    step(0, 0, 0, 1, 32'hDEADBEEF);
    chk1("t1_m0_rv", m0_rvalid_o, 1); chk1("t1_m1_rv", m1_rvalid_o, 0);
    chk32("t1_rdata", m0_rdata_o, 32'hDEADBEEF); chk1("t1_err", err_o, 0);

    // 2: both request every cycle, grants alternate starting at port 0.
    do_reset();
    step(1, 1, 1, 0, 0);
    chk1("t2_c0_g0", m0_gnt_o, 1); chk1("t2_c0_g1", m1_gnt_o, 0);
    step(1, 1, 1, 1, 1);
    chk1("t2_c1_g1", m1_gnt_o, 1); chk32("t2_c1_addr", s_addr_o, 32'h2000);
    chk1("t2_c1_rv0", m0_rvalid_o, 1); chk32("t2_c1_be", {28'd0, s_be_o}, 32'h3);
    step(1, 1, 1, 1, 2);
    chk1("t2_c2_g0", m0_gnt_o, 1); chk1("t2_c2_rv1", m1_rvalid_o, 1);
    step(1, 1, 1, 1, 3);
    chk1("t2_c3_g1", m1_gnt_o, 1); chk32("t2_c3_addr", s_addr_o, 32'h2000);
    chk1("t2_c3_rv0", m0_rvalid_o, 1);
    step(0, 0, 0, 1, 4);
    chk1("t2_c4_rv1", m1_rvalid_o, 1);

    // 3: stalled m1 request stays locked although m0 joins.
    step(0, 1, 0, 0, 0);
    chk32("t3_c0_addr", s_addr_o, 32'h2000); chk1("t3_c0_req", s_req_o, 1);
    step(1, 1, 0, 0, 0);
    chk32("t3_c1_addr", s_addr_o, 32'h2000);
    step(1, 1, 0, 0, 0);
    chk32("t3_c2_addr", s_addr_o, 32'h2000); chk1("t3_c2_g1", m1_gnt_o, 0);
    step(1, 1, 1, 0, 0);
    chk32("t3_c3_addr", s_addr_o, 32'h2000);
    chk1("t3_c3_g1", m1_gnt_o, 1); chk1("t3_c3_g0", m0_gnt_o, 0);
    step(1, 0, 1, 0, 0);
    chk1("t3_c4_g0", m0_gnt_o, 1);
    step(0, 0, 0, 1, 0);
    chk1("t3_rv1", m1_rvalid_o, 1);
    step(0, 0, 0, 1, 0);
    chk1("t3_rv0", m0_rvalid_o, 1);

    // 4: two in flight saturates the port; no same-cycle bypass on pop.
    step(1, 0, 1, 0, 0);
    chk1("t4_g0", m0_gnt_o, 1);
    step(0, 1, 1, 0, 0);
    chk1("t4_g1", m1_gnt_o, 1);
    step(1, 1, 1, 0, 0);
    chk1("t4_full_req", s_req_o, 0);
    chk1("t4_full_g0", m0_gnt_o, 0); chk1("t4_full_g1", m1_gnt_o, 0);
    step(1, 1, 1, 1, 0);
    chk1("t4_nobypass", s_req_o, 0); chk1("t4_nobypass_g", m0_gnt_o | m1_gnt_o, 0);
    chk1("t4_rv0", m0_rvalid_o, 1);
    step(0, 0, 0, 1, 0);
    chk1("t4_rv1", m1_rvalid_o, 1);

    // 5: grant and response in the same cycle; then 6: response with nothing outstanding.
    step(1, 0, 1, 0, 0);
    chk1("t5_g0", m0_gnt_o, 1);
    step(0, 1, 1, 1, 0);
    chk1("t5_rv0", m0_rvalid_o, 1); chk1("t5_g1", m1_gnt_o, 1);
    step(0, 0, 0, 1, 0);
    chk1("t5_rv1", m1_rvalid_o, 1); chk1("t5_err", err_o, 0);
    step(0, 0, 0, 1, 0);
    chk1("t6_err", err_o, 1);
    chk1("t6_rv0", m0_rvalid_o, 0); chk1("t6_rv1", m1_rvalid_o, 0);
    step(0, 0, 0, 0, 0);
    chk1("t6_err_pulse", err_o, 0);

    // 6b: reset while locked with a transaction in flight.
    step(1, 0, 1, 0, 0);
    chk1("t6_g0", m0_gnt_o, 1);
    step(1, 0, 0, 0, 0);
    chk1("t6_lock_req", s_req_o, 1);
    step(1, 1, 0, 0, 0);
    chk32("t6_locked_addr", s_addr_o, 32'h1000);
    #1 rst_i = 1'b1; s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 32'h5555_5555;
    #1;
    chk1("t6_rst_req", s_req_o, 0);
    chk1("t6_rst_g", m0_gnt_o | m1_gnt_o, 0);
    chk1("t6_rst_rv", m0_rvalid_o | m1_rvalid_o, 0);
    chk1("t6_rst_err", err_o, 0);
    chk32("t6_rst_addr", s_addr_o, 0);
    chk32("t6_rst_rdata", m1_rdata_o, 0);
    @(posedge clk_i); #1;
    rst_i = 0; m0_req_i = 0; m1_req_i = 0; s_gnt_i = 0; s_rvalid_i = 0;
    step(0, 1, 0, 1, 0);
    chk32("t6_idle_addr", s_addr_o, 32'h2000); chk1("t6_idle_req", s_req_o, 1);
    chk1("t6_late_err", err_o, 1); chk1("t6_late_rv0", m0_rvalid_o, 0);

    // Randomized traffic against the request-level model.
    do_reset();
    q.delete(); rr = 0; lk = 0; lk_own = 0; hold[0] = 0; hold[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk_i); #1;
      for (int p = 0; p < 2; p++) begin
        if (!hold[p] && $urandom_range(1, 0) == 1) begin
          hold[p] = 1;
          ra[p] = $urandom; rw[p] = $urandom;
          rwe[p] = 1'($urandom_range(1, 0)); rbe[p] = 4'($urandom_range(15, 0));
        end
      end
      gnt = 1'($urandom_range(1, 0));
      rv  = (q.size() > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(19, 0) == 0);
      rd  = $urandom;
      m0_req_i = hold[0]; m0_addr_i = ra[0]; m0_we_i = rwe[0]; m0_be_i = rbe[0]; m0_wdata_i = rw[0];
      m1_req_i = hold[1]; m1_addr_i = ra[1]; m1_we_i = rwe[1]; m1_be_i = rbe[1]; m1_wdata_i = rw[1];
      s_gnt_i = gnt; s_rvalid_i = rv; s_rdata_i = rd;
      #3;
      if (lk)                      e_sel = lk_own;
      else if (hold[0] && hold[1]) e_sel = rr;
      else if (hold[1])            e_sel = 1;
      else                         e_sel = 0;
      e_req = hold[e_sel] && (q.size() < MO);
      e_g0  = e_req && gnt && (e_sel == 0);
      e_g1  = e_req && gnt && (e_sel == 1);
      e_rv0 = rv && (q.size() > 0) && (q[0] == 0);
      e_rv1 = rv && (q.size() > 0) && (q[0] == 1);
      e_err = rv && (q.size() == 0);
      chk1("rnd_req", s_req_o, e_req);
      chk1("rnd_g0", m0_gnt_o, e_g0);
      chk1("rnd_g1", m1_gnt_o, e_g1);
      chk1("rnd_rv0", m0_rvalid_o, e_rv0);
      chk1("rnd_rv1", m1_rvalid_o, e_rv1);
      chk1("rnd_err", err_o, e_err);
      chk32("rnd_rdata", m1_rdata_o, rd);
      if (e_req) begin
        chk32("rnd_addr", s_addr_o, ra[e_sel]);
        chk32("rnd_wdata", s_wdata_o, rw[e_sel]);
        chk1("rnd_we", s_we_o, rwe[e_sel]);
        chk32("rnd_be", {28'd0, s_be_o}, {28'd0, rbe[e_sel]});
      end
      if (rv && q.size() > 0) void'(q.pop_front());
      if (e_g0 || e_g1) begin
        q.push_back(e_sel);
        rr = 1 - e_sel;
        lk = 0;
        hold[e_sel] = 0;
      end else if (e_req) begin
        lk = 1;
        lk_own = e_sel;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
